// File: rtl/fp_norm_round_unit_pkg.sv
// Shared types and constants for the FPU normalise-and-round stage.
//  rnd_mode_t   : IEEE rounding modes as encoded on the rnd_mode port.
//  norm_state_t : control states of the normalise/round sequencer.
//  EXP_MAX/EXP_BIAS : single-precision defaults (EXP_W = 8).
//  round_to_inf : decides whether an overflowed result saturates to infinity
//                 or to the largest finite magnitude.
package fp_norm_round_unit_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } norm_state_t;

  localparam int EXP_MAX  = 255;
  localparam int EXP_BIAS = 127;

  // Overflow goes to infinity only when the mode rounds away from zero
  // in the direction of the result's sign (RNE always does).
  function automatic logic round_to_inf(input rnd_mode_t mode, input logic sign);
    logic inf_s;
    case (mode)
      RND_RNE: inf_s = 1'b1;
      RND_RTZ: inf_s = 1'b0;
      RND_RUP: inf_s = ~sign;
      RND_RDN: inf_s = sign;
      default: inf_s = 1'b1;
    endcase
    return inf_s;
  endfunction

endpackage

// File: rtl/fp_norm_round_unit_round_inc.sv
// fp_round_inc: combinational rounding decision and fraction increment.
//  frac     in  MAN_W  truncated fraction (hidden bit excluded)
//  guard    in  1      first discarded bit
//  sticky   in  1      OR of all remaining discarded bits
//  sign     in  1      result sign (directed modes)
//  mode     in  2      rounding mode
//  frac_out out MAN_W  rounded fraction (all zero on carry-out)
//  carry    out 1      fraction overflowed into the exponent
//  inexact  out 1      any discarded bit was set
module fp_round_inc
  import fp_norm_round_unit_pkg::*;
#(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] frac,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  rnd_mode_t        mode,
  output logic [MAN_W-1:0] frac_out,
  output logic             carry,
  output logic             inexact
);

  logic             inc_s;
  logic [MAN_W:0]   sum_s;

  // Round-up decision for each mode.
  always_comb begin
    inc_s = 1'b0;
    case (mode)
      RND_RNE: inc_s = guard & (sticky | frac[0]);
      RND_RTZ: inc_s = 1'b0;
      RND_RUP: inc_s = (guard | sticky) & ~sign;
      RND_RDN: inc_s = (guard | sticky) & sign;
      default: inc_s = 1'b0;
    endcase
  end

  assign sum_s    = {1'b0, frac} + {{MAN_W{1'b0}}, inc_s};
  assign frac_out = sum_s[MAN_W-1:0];
  assign carry    = sum_s[MAN_W];
  assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_norm_round_unit.sv
// fp_norm_round_unit: multi-cycle normalise-and-round stage after the
// significand multiplier. Normalises the raw product (one right shift or
// one left shift per cycle), rounds in one of four IEEE modes and flags
// overflow / underflow (flush to zero) / inexact.
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid/in_ready     operand handshake (ready only while idle)
//  product               unsigned PROD_W-bit significand product
//  exp_in                signed biased exponent sum, EXP_W+2 bits
//  sign_in, rnd_mode     result sign, rounding mode (sampled at accept)
//  out_valid/out_ready   result handshake; outputs held until taken
//  man_out, exp_out      rounded fraction, final biased exponent
//  sign_out              result sign
//  overflow, underflow, inexact  exception flags
module fp_norm_round_unit
  import fp_norm_round_unit_pkg::*;
#(
  parameter int MAN_W  = 23,
  parameter int EXP_W  = 8,
  parameter int PROD_W = 2 * (MAN_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PROD_W-1:0]       product,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic                    sign_in,
  input  logic [1:0]              rnd_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MAN_W-1:0]        man_out,
  output logic [EXP_W-1:0]        exp_out,
  output logic                    sign_out,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);

  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_INF  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

  norm_state_t           state_q, state_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic                  sign_q, sign_d;
  rnd_mode_t             mode_q, mode_d;
  logic                  sticky_q, sticky_d;   // bit lost by the right shift
  logic                  zero_q, zero_d;       // product was zero
  logic                  ufp_q, ufp_d;         // exponent floor hit while unnormalised
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [MAN_W-1:0]      man_q, man_d;
  logic [EXP_W-1:0]      expo_q, expo_d;
  logic                  signo_q, signo_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  inx_q, inx_d;

  logic [MAN_W-1:0]      rnd_frac_s;
  logic                  rnd_carry_s;
  logic                  rnd_inx_s;
  logic signed [XW-1:0]  exp_rnd_s;
  logic [MAN_W-1:0]      res_man_s;
  logic [EXP_W-1:0]      res_exp_s;
  logic                  res_ovf_s, res_unf_s, res_inx_s;

  // Binary point sits below bit PROD_W-2, so the stored fraction starts at PROD_W-3.
  fp_round_inc #(.MAN_W(MAN_W)) u_round_inc (
    .frac     (prod_q[PROD_W-3 -: MAN_W]),
    .guard    (prod_q[PROD_W-3-MAN_W]),
    .sticky   ((|prod_q[PROD_W-4-MAN_W:0]) | sticky_q),
    .sign     (sign_q),
    .mode     (mode_q),
    .frac_out (rnd_frac_s),
    .carry    (rnd_carry_s),
    .inexact  (rnd_inx_s)
  );

  assign exp_rnd_s = exp_q + XW'(rnd_carry_s);

  // Final result selection: zero bypass, overflow saturation, flush-to-zero, normal.
  always_comb begin
    res_man_s = {MAN_W{1'b0}};
    res_exp_s = {EXP_W{1'b0}};
    res_ovf_s = 1'b0;
    res_unf_s = 1'b0;
    res_inx_s = 1'b0;
    if (zero_q) begin
      res_man_s = {MAN_W{1'b0}};
    end else if (exp_rnd_s >= EXP_TOP) begin
      res_ovf_s = 1'b1;
      res_inx_s = 1'b1;
      if (round_to_inf(mode_q, sign_q)) begin
        res_exp_s = EXP_INF;
        res_man_s = {MAN_W{1'b0}};
      end else begin
        res_exp_s = EXP_MAXF;
        res_man_s = {MAN_W{1'b1}};
      end
    end else if ((exp_rnd_s <= EXP_ZERO) || ufp_q) begin
      res_unf_s = 1'b1;
      res_inx_s = 1'b1;
    end else begin
      res_man_s = rnd_frac_s;
      res_exp_s = exp_rnd_s[EXP_W-1:0];
      res_inx_s = rnd_inx_s;
    end
  end

  // Sequencer next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    mode_d      = mode_q;
    sticky_d    = sticky_q;
    zero_d      = zero_q;
    ufp_d       = ufp_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    man_d       = man_q;
    expo_d      = expo_q;
    signo_d     = signo_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          prod_d     = product;
          exp_d      = exp_in;
          sign_d     = sign_in;
          mode_d     = rnd_mode_t'(rnd_mode);
          sticky_d   = 1'b0;
          zero_d     = 1'b0;
          ufp_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_NORM;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_NORM: begin
        if (prod_q == {PROD_W{1'b0}}) begin
          zero_d   = 1'b1;
          state_d  = S_ROUND;
        end else if (prod_q[PROD_W-1]) begin
          prod_d   = prod_q >> 1;
          sticky_d = sticky_q | prod_q[0];
          exp_d    = exp_q + EXP_ONE;
          state_d  = S_ROUND;
        end else if (prod_q[PROD_W-2]) begin
          state_d  = S_ROUND;
        end else if (exp_q > EXP_ONE) begin
          prod_d   = prod_q << 1;
          exp_d    = exp_q - EXP_ONE;
        end else begin
          ufp_d    = 1'b1;
          state_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        out_valid_d = 1'b1;
        man_d       = res_man_s;
        expo_d      = res_exp_s;
        signo_d     = sign_q;
        ovf_d       = res_ovf_s;
        unf_d       = res_unf_s;
        inx_d       = res_inx_s;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prod_q      <= {PROD_W{1'b0}};
      exp_q       <= EXP_ZERO;
      sign_q      <= 1'b0;
      mode_q      <= RND_RNE;
      sticky_q    <= 1'b0;
      zero_q      <= 1'b0;
      ufp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      man_q       <= {MAN_W{1'b0}};
      expo_q      <= {EXP_W{1'b0}};
      signo_q     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      mode_q      <= mode_d;
      sticky_q    <= sticky_d;
      zero_q      <= zero_d;
      ufp_q       <= ufp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      man_q       <= man_d;
      expo_q      <= expo_d;
      signo_q     <= signo_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign man_out   = man_q;
  assign exp_out   = expo_q;
  assign sign_out  = signo_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_norm_round_unit.sv
// Scoreboard bench for fp_norm_round_unit (MAN_W=23, EXP_W=8).
// Directed cases push hand-derived expectations; random cases push the
// result of a value-level rounding model.
module tb_fp_norm_round_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] product = 48'h0;
  logic [9:0]  exp_in = 10'h0;
  logic        sign_in = 1'b0;
  logic [1:0]  rnd_mode = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] man_out;
  logic [7:0]  exp_out;
  logic        sign_out, overflow, underflow, inexact;

  typedef struct {
    logic [22:0] man;
    logic [7:0]  ex;
    logic        sg, ov, uf, ix;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  bit     stall_req = 1'b0;

  fp_norm_round_unit #(.MAN_W(23), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .exp_in(exp_in), .sign_in(sign_in), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .man_out(man_out),
    .exp_out(exp_out), .sign_out(sign_out), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [22:0] man, input logic [7:0] ex, input logic sg,
                              input logic ov, input logic uf, input logic ix, input int lat);
    exp_t r;
    r.man = man; r.ex = ex; r.sg = sg; r.ov = ov; r.uf = uf; r.ix = ix; r.lat = lat; r.acc = 0;
    return r;
  endfunction

  // Value-level reference: locate the leading one, round at the right position.
  function automatic exp_t model(input logic [47:0] p, input int e_in, input logic s, input logic [1:0] m);
    exp_t   r;
    int     e, msb, shifts, pos;
    longint sig, frac, rem, half, mm;
    bit     up;
    r = mk(23'h0, 8'h0, s, 1'b0, 1'b0, 1'b0, 2);
    if (p == 48'h0) return r;
    e = e_in; msb = 0; shifts = 0; pos = 23;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    if (msb == 47) begin
      e = e + 1; pos = 24;
    end else if (msb < 46) begin
      shifts = 46 - msb;
      if (e - 1 < shifts) begin
        r.lat = 2 + ((e > 1) ? e - 1 : 0);
        r.uf = 1'b1; r.ix = 1'b1;
        return r;
      end
      e = e - shifts;
      r.lat = 2 + shifts;
    end
    sig  = longint'(p) << shifts;
    frac = (sig >> pos) & 64'h7FFFFF;
    rem  = sig & ((64'sd1 << pos) - 64'sd1);
    half = 64'sd1 << (pos - 1);
    case (m)
      2'd0:    up = (rem > half) || ((rem == half) && frac[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = (rem != 0) && !s;
      default: up = (rem != 0) && s;
    endcase
    mm = frac + longint'(up);
    if (mm == 64'h800000) begin mm = 0; e = e + 1; end
    if (e >= 255) begin
      r.ov = 1'b1; r.ix = 1'b1;
      if (m == 2'd0 || (m == 2'd2 && !s) || (m == 2'd3 && s)) begin
        r.ex = 8'hFF; r.man = 23'h0;
      end else begin
        r.ex = 8'hFE; r.man = 23'h7FFFFF;
      end
    end else if (e <= 0) begin
      r.uf = 1'b1; r.ix = 1'b1;
    end else begin
      r.ex = e[7:0]; r.man = mm[22:0]; r.ix = (rem != 0);
    end
    return r;
  endfunction

  task automatic issue(input logic [47:0] p, input int e, input logic s, input logic [1:0] m,
                       input exp_t x, input bit push);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin @(negedge clk); w++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", w);
    end else begin
      product = p; exp_in = e[9:0]; sign_in = s; rnd_mode = m; in_valid = 1'b1;
      @(posedge clk); #1;
      x.acc = cyc;
      if (push) sb.push_back(x);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid || !in_ready) && w < 3000) begin @(negedge clk); w++; end
    if (w >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  // Monitor: compare each new result, then check it stays stable while held.
  initial begin : monitor
    exp_t        e;
    bit          have;
    int          hold;
    logic [36:0] held;
    have = 1'b0; hold = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0; hold = 0; out_ready = 1'b0;
      end else if (out_valid) begin
        if (!have) begin
          have = 1'b1;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: man %0h exp %0h", man_out, exp_out);
          end else begin
            e = sb.pop_front();
            check("man", 64'(man_out), 64'(e.man));
            check("exp", 64'(exp_out), 64'(e.ex));
            check("sign", 64'(sign_out), 64'(e.sg));
            check("flags ov/uf/ix", 64'({overflow, underflow, inexact}), 64'({e.ov, e.uf, e.ix}));
            check("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          held = {man_out, exp_out, sign_out, overflow, underflow, inexact};
          hold = stall_req ? 10 : $urandom_range(0, 2);
          stall_req = 1'b0;
        end else begin
          check("hold_stable", 64'({man_out, exp_out, sign_out, overflow, underflow, inexact}), 64'(held));
        end
        check("in_ready_busy", 64'(in_ready), 64'(0));
        if (hold > 0) begin hold--; out_ready = 1'b0; end
        else out_ready = 1'b1;
      end else begin
        have = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed corners, stall, mid-op reset, then random operands.
  initial begin : driver
    exp_t        x;
    logic [47:0] p;
    int          e;
    logic        s;
    logic [1:0]  m;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, man_out, exp_out, sign_out, overflow, underflow, inexact}), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    issue(48'h900000000000, 128, 1'b0, 2'd0, mk(23'h100000, 8'd129, 1'b0, 1'b0, 1'b0, 1'b0, 2), 1'b1);
    issue(48'h400000400000, 127, 1'b0, 2'd0, mk(23'h000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h400000C00000, 127, 1'b0, 2'd0, mk(23'h000002, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h7FFFFFC00000, 127, 1'b0, 2'd0, mk(23'h000000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h800000000000, 254, 1'b0, 2'd0, mk(23'h000000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h800000000000, 254, 1'b0, 2'd1, mk(23'h7FFFFF, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h800000000000, 254, 1'b1, 2'd2, mk(23'h7FFFFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h800000000000, 254, 1'b1, 2'd3, mk(23'h000000, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 2), 1'b1);
    issue(48'h100000000000, 130, 1'b0, 2'd0, mk(23'h000000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 4), 1'b1);
    issue(48'h000000000000, 50,  1'b0, 2'd0, mk(23'h000000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 2), 1'b1);
    issue(48'h100000000000, 2,   1'b0, 2'd0, mk(23'h000000, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1, 3), 1'b1);

    // Consumer stalls for 10 cycles.
    drain();
    stall_req = 1'b1;
    issue(48'h900000000000, 128, 1'b0, 2'd0, mk(23'h100000, 8'd129, 1'b0, 1'b0, 1'b0, 1'b0, 2), 1'b1);

    // Reset while the unit is still left-shifting.
    drain();
    issue(48'h000000800000, 100, 1'b0, 2'd0, x, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    check("midreset_outputs", 64'({man_out, exp_out, overflow, underflow, inexact}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(48'h900000000000, 128, 1'b0, 2'd0, mk(23'h100000, 8'd129, 1'b0, 1'b0, 1'b0, 1'b0, 2), 1'b1);

    for (int n = 0; n < 250; n++) begin
      p = {$urandom, $urandom} >> $urandom_range(0, 47);
      if ($urandom_range(0, 3) == 0) p[21:0] = 22'h0;
      if ($urandom_range(0, 7) == 0) p[22] = 1'b1;
      if (p == 48'h0) p = 48'h1;
      e = int'($urandom_range(0, 263)) - 4;
      s = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      issue(p, e, s, m, model(p, e, s, m), 1'b1);
    end

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
